// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_pkg
// Purpose  : Shared types and default sizes for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int c_ADDR_W_DEFAULT       = 9;
    localparam int c_DATA_W_DEFAULT       = 32;
    localparam int c_STARVE_LIMIT_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares the data memory between the MEM stage (priority) and a
//            host port with starvation bound and lock mode.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = c_STARVE_LIMIT_DEFAULT,
    parameter int ADDR_W       = c_ADDR_W_DEFAULT,
    parameter int DATA_W       = c_DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_valid,
    input  logic              host_we,
    input  logic              host_lock,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wen,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int                 c_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    arb_state_e          r_state;
    logic [c_CNT_W-1:0]  r_wait_cnt;
    logic                r_host_rvalid;
    logic [DATA_W-1:0]   r_host_rdata;

    logic                w_host_grant;
    logic                w_cpu_grant;

    // Lock ownership grants the host unconditionally; otherwise it only
    // wins an idle cycle or once its wait has reached the starvation bound.
    assign w_host_grant = host_valid &&
                          ((r_state == LOCKED) || !cpu_req || (r_wait_cnt == c_LIMIT));
    assign w_cpu_grant  = cpu_req && !w_host_grant;

    assign host_ready  = w_host_grant;
    assign cpu_stall   = cpu_req && (w_host_grant || (r_state == LOCKED));
    assign cpu_rdata   = mem_dout;
    assign host_rvalid = r_host_rvalid;
    assign host_rdata  = r_host_rdata;

    always_comb begin
        mem_addr = cpu_addr;
        mem_din  = cpu_wdata;
        mem_wen  = 1'b0;
        if (w_host_grant) begin
            mem_addr = host_addr;
            mem_din  = host_wdata;
            mem_wen  = host_we;
        end else if (w_cpu_grant) begin
            mem_wen  = cpu_we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ARB;
            r_wait_cnt    <= '0;
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= '0;
        end else begin
            case (r_state)
                ARB:     if (w_host_grant && host_lock) r_state <= LOCKED;
                LOCKED:  if (!host_lock) r_state <= ARB;
                default: r_state <= ARB;
            endcase

            if (w_host_grant || !host_valid) begin
                r_wait_cnt <= '0;
            end else if (cpu_req && (r_wait_cnt != c_LIMIT)) begin
                r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
            end

            r_host_rvalid <= w_host_grant && !host_we;
            if (w_host_grant && !host_we) begin
                r_host_rdata <= mem_dout;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter with a behavioural memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [8:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        host_valid, host_we, host_lock;
    logic [8:0]  host_addr;
    logic [31:0] host_wdata;
    logic        host_ready, host_rvalid;
    logic [31:0] host_rdata;
    logic [8:0]  mem_addr;
    logic [31:0] mem_din;
    logic        mem_wen;
    logic [31:0] mem_dout;

    logic [31:0] mem     [0:511];
    logic [31:0] ref_mem [0:511];
    logic [31:0] sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    dmem_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .host_valid (host_valid),
        .host_we    (host_we),
        .host_lock  (host_lock),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ready (host_ready),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_wen    (mem_wen),
        .mem_dout   (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_dout = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_din;
    end

    typedef struct {
        logic cpu_req;
        logic cpu_we;
        logic host_valid;
        logic host_we;
        logic exp_ready;
        logic exp_stall;
        logic exp_wen;
        logic exp_host_sel;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_check();
        if (host_rvalid) begin
            if (sb_q.size() == 0) begin
                check("rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                check("host_rdata", host_rdata, sb_q.pop_front());
            end
        end else if (sb_q.size() != 0) begin
            check("rvalid_missing", 32'd0, 32'd1);
            sb_q.delete();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sb_check();
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        host_valid = 0; host_we = 0; host_lock = 0; host_addr = '0; host_wdata = '0;
    endtask

    // Counts cycles until host_ready; the CPU must never stall while waiting.
    task automatic host_wait_grant(input int exp_cycles, input string name);
        int n = 0;
        #1;
        while (!host_ready && n < 20) begin
            check({name, "_stall"}, 32'(cpu_stall), 32'd0);
            tick();
            n++;
        end
        if (!host_ready) check({name, "_timeout"}, 32'(n), 32'(exp_cycles));
        else             check(name, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{1, 0, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{1, 1, 0, 0, 0, 0, 1, 0};
        vecs[3] = '{0, 0, 1, 0, 1, 0, 0, 1};
        vecs[4] = '{0, 0, 1, 1, 1, 0, 1, 1};
        vecs[5] = '{1, 0, 1, 1, 0, 0, 0, 0};
        vecs[6] = '{1, 1, 1, 0, 0, 0, 1, 0};
        vecs[7] = '{0, 1, 0, 1, 0, 0, 0, 0};

        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rvalid", 32'(host_rvalid), 32'd0);
        check("reset_rdata", host_rdata, 32'd0);
        rst_n = 1;
        tick();

        // Combinational grant table in ARB with an empty wait counter.
        for (int i = 0; i < 8; i++) begin
            cpu_req = vecs[i].cpu_req;   cpu_we = vecs[i].cpu_we;
            host_valid = vecs[i].host_valid; host_we = vecs[i].host_we;
            cpu_addr = 9'h01A;  cpu_wdata = 32'hC0C0_0001;
            host_addr = 9'h155; host_wdata = 32'hB0B0_0002;
            #1;
            check($sformatf("vec%0d_ready", i), 32'(host_ready), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d_stall", i), 32'(cpu_stall), 32'(vecs[i].exp_stall));
            check($sformatf("vec%0d_wen", i), 32'(mem_wen), 32'(vecs[i].exp_wen));
            check($sformatf("vec%0d_addr", i), 32'(mem_addr),
                  vecs[i].exp_host_sel ? 32'h155 : 32'h01A);
            if (vecs[i].exp_wen)
                check($sformatf("vec%0d_din", i), mem_din,
                      vecs[i].exp_host_sel ? 32'hB0B0_0002 : 32'hC0C0_0001);
            idle_inputs();
            tick();
        end

        // Idle CPU: host write then read of addr 5.
        host_valid = 1; host_we = 1; host_addr = 9'd5; host_wdata = 32'hDEAD_BEEF;
        #1;
        check("idle_wr_ready", 32'(host_ready), 32'd1);
        check("idle_wr_stall", 32'(cpu_stall), 32'd0);
        tick();
        ref_mem[5] = 32'hDEAD_BEEF;
        host_valid = 0;
        check("idle_wr_commit", mem[5], ref_mem[5]);
        host_valid = 1; host_we = 0;
        #1;
        check("idle_rd_ready", 32'(host_ready), 32'd1);
        check("idle_rd_stall", 32'(cpu_stall), 32'd0);
        sb_q.push_back(ref_mem[5]);
        tick();
        check("idle_rd_rvalid", 32'(host_rvalid), 32'd1);
        host_valid = 0;
        tick();
        check("idle_rvalid_drop", 32'(host_rvalid), 32'd0);

        // Continuous CPU traffic: host read is forced after STARVE_LIMIT cycles.
        cpu_req = 1; cpu_addr = 9'd3;
        host_valid = 1; host_we = 0; host_addr = 9'd5;
        host_wait_grant(4, "starve_wait");
        check("starve_stall", 32'(cpu_stall), 32'd1);
        sb_q.push_back(ref_mem[5]);
        tick();
        host_valid = 0;
        #1;
        check("starve_retry_stall", 32'(cpu_stall), 32'd0);
        check("starve_retry_addr", 32'(mem_addr), 32'd3);

        // Lock mode: 8 back-to-back host writes under continuous CPU load.
        host_valid = 1; host_we = 1; host_lock = 1;
        host_addr = 9'd0; host_wdata = 32'hA000_0000;
        host_wait_grant(4, "lock_first_wait");
        check("lock0_stall", 32'(cpu_stall), 32'd1);
        tick();
        ref_mem[0] = 32'hA000_0000;
        for (int i = 1; i < 8; i++) begin
            host_addr = 9'(i); host_wdata = 32'hA000_0000 + 32'(i);
            #1;
            check($sformatf("lock%0d_ready", i), 32'(host_ready), 32'd1);
            check($sformatf("lock%0d_stall", i), 32'(cpu_stall), 32'd1);
            tick();
            ref_mem[i] = 32'hA000_0000 + 32'(i);
        end
        host_valid = 0;
        #1;
        check("lock_idle_stall", 32'(cpu_stall), 32'd1);
        check("lock_idle_wen", 32'(mem_wen), 32'd0);
        tick();
        host_lock = 0;
        #1;
        check("lock_drop_stall", 32'(cpu_stall), 32'd1);
        tick();
        check("unlock_stall", 32'(cpu_stall), 32'd0);
        check("unlock_cpu_load", cpu_rdata, ref_mem[3]);
        for (int i = 0; i < 8; i++) check($sformatf("lock_mem%0d", i), mem[i], ref_mem[i]);

        // Same-address collision: forced host store first, CPU store on retry.
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'd20;
        host_valid = 1; host_we = 1; host_addr = 9'd9; host_wdata = 32'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("coll_wait%0d", k), 32'(host_ready), 32'd0);
            tick();
        end
        cpu_we = 1; cpu_addr = 9'd9; cpu_wdata = 32'h11;
        #1;
        check("coll_host_ready", 32'(host_ready), 32'd1);
        check("coll_stall", 32'(cpu_stall), 32'd1);
        tick();
        host_valid = 0;
        check("coll_host_first", mem[9], 32'h22);
        #1;
        check("coll_retry_stall", 32'(cpu_stall), 32'd0);
        check("coll_retry_wen", 32'(mem_wen), 32'd1);
        tick();
        cpu_req = 0; cpu_we = 0;
        check("coll_final", mem[9], 32'h11);

        // Asynchronous reset while LOCKED with read data pending.
        host_valid = 1; host_we = 0; host_lock = 1; host_addr = 9'd5;
        #1;
        check("rst_lock_ready", 32'(host_ready), 32'd1);
        sb_q.push_back(ref_mem[5]);
        tick();
        check("rst_pre_rvalid", 32'(host_rvalid), 32'd1);
        host_valid = 0; cpu_req = 1; cpu_addr = 9'd3;
        #1;
        check("rst_pre_stall", 32'(cpu_stall), 32'd1);
        rst_n = 0;
        #1;
        check("rst_rvalid", 32'(host_rvalid), 32'd0);
        check("rst_rdata", host_rdata, 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        host_lock = 0;
        tick();
        rst_n = 1;
        host_valid = 1; host_we = 0; host_addr = 9'd5;
        host_wait_grant(4, "post_reset_wait");
        sb_q.push_back(ref_mem[5]);
        tick();
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
